// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature A/B decoder with wrapping N-bit position count
// Optional index-pulse zeroing is built when QDEC_INDEX_EN is defined.
module quad_decoder #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         qa,
    input  logic         qb,
    input  logic         en,
`ifdef QDEC_INDEX_EN
    input  logic         idx,
`endif
    output logic [N-1:0] count,
    output logic         dir,
    output logic         step,
    output logic         err
);

    localparam int            PW         = $clog2(SYNC_STAGES + 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES);
    localparam logic [N-1:0]  ONE        = N'(1);

    typedef enum logic {PRIME, RUN} state_t;

    state_t                 state_q;
    logic [PW-1:0]          prime_cnt_q;
    logic [SYNC_STAGES-1:0] qa_sync_q;
    logic [SYNC_STAGES-1:0] qb_sync_q;
    logic [1:0]             prev_q;
    logic [N-1:0]           count_q;
    logic                   dir_q;
    logic                   step_q;
    logic                   err_q;

    logic [1:0]             cur;
    logic                   fwd;
    logic                   rev;
    logic                   bad;
    logic [N-1:0]           count_d;
    logic                   dir_d;
    logic                   step_d;
    logic                   err_d;

`ifdef QDEC_INDEX_EN
    logic [SYNC_STAGES-1:0] idx_sync_q;
    logic                   idx_prev_q;
    logic                   idx_rise;

    assign idx_rise = idx_sync_q[SYNC_STAGES-1] & ~idx_prev_q;
`endif

    assign cur = {qa_sync_q[SYNC_STAGES-1], qb_sync_q[SYNC_STAGES-1]};

    // Gray-code step classification, A in the high bit
    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        bad = 1'b0;
        case ({prev_q, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = bad;
        if (en && fwd) begin
            count_d = count_q + ONE;
            dir_d   = 1'b0;
            step_d  = 1'b1;
        end else if (en && rev) begin
            count_d = count_q - ONE;
            dir_d   = 1'b1;
            step_d  = 1'b1;
        end
`ifdef QDEC_INDEX_EN
        if (en && idx_rise) begin
            count_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PRIME;
            prime_cnt_q <= '0;
            qa_sync_q   <= '0;
            qb_sync_q   <= '0;
            prev_q      <= 2'b00;
            count_q     <= '0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef QDEC_INDEX_EN
            idx_sync_q  <= '0;
            idx_prev_q  <= 1'b0;
`endif
        end else begin
            qa_sync_q <= {qa_sync_q[SYNC_STAGES-2:0], qa};
            qb_sync_q <= {qb_sync_q[SYNC_STAGES-2:0], qb};
            prev_q    <= cur;
`ifdef QDEC_INDEX_EN
            idx_sync_q <= {idx_sync_q[SYNC_STAGES-2:0], idx};
            idx_prev_q <= idx_sync_q[SYNC_STAGES-1];
`endif
            case (state_q)
                PRIME: begin
                    // wait for the synchronizer to fill before trusting prev
                    step_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (prime_cnt_q == PRIME_LAST) begin
                        state_q <= RUN;
                    end else begin
                        prime_cnt_q <= prime_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    count_q <= count_d;
                    dir_q   <= dir_d;
                    step_q  <= step_d;
                    err_q   <= err_d;
                end
                default: state_q <= PRIME;
            endcase
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign step  = step_q;
    assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed self-checking bench for quad_decoder
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       qa  = 1'b1;
    logic       qb  = 1'b1;
    logic       en  = 1'b1;
`ifdef QDEC_INDEX_EN
    logic       idx = 1'b0;
`endif
    logic [3:0] count;
    logic       dir;
    logic       step;
    logic       err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    quad_decoder #(.N(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .qa    (qa),
        .qb    (qb),
        .en    (en),
`ifdef QDEC_INDEX_EN
        .idx   (idx),
`endif
        .count (count),
        .dir   (dir),
        .step  (step),
        .err   (err)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; qa = 1'b1; qb = 1'b1; en = 1'b1;
        cyc(2);
        checks++;
        if (count !== 4'd0 || dir !== 1'b0) begin
            errors++; $display("FAIL reset_state: count=%0d dir=%0d expected 0/0", count, dir);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            checks++;
            if (step !== 1'b0 || err !== 1'b0 || count !== 4'd0) begin
                errors++;
                $display("FAIL reset_prime cycle %0d: step=%0d err=%0d count=%0d expected 0/0/0", k, step, err, count);
            end
        end
    endtask

    task automatic test_forward;
        logic [1:0] seq [6];
        int pulses;
        seq = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            {qa, qb} = seq[i];
            for (int k = 1; k <= 4; k++) begin
                cyc(1);
                if (step === 1'b1) pulses++;
                checks++;
                if (step !== (k == 3)) begin
                    errors++;
                    $display("FAIL fwd_step_latency i=%0d k=%0d: step=%0d expected %0d", i, k, step, (k == 3));
                end
                if (k == 3) begin
                    checks++;
                    if (count !== 4'(i + 1)) begin
                        errors++; $display("FAIL fwd_count i=%0d: count=%0d expected %0d", i, count, i + 1);
                    end
                end
            end
        end
        checks++;
        if (count !== 4'd6 || dir !== 1'b0 || pulses != 6) begin
            errors++;
            $display("FAIL fwd_final: count=%0d dir=%0d pulses=%0d expected 6/0/6", count, dir, pulses);
        end
    endtask

    task automatic test_reverse_wrap;
        rst = 1'b1; qa = 1'b0; qb = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(4);
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL rev_start: count=%0d expected 0", count);
        end
        {qa, qb} = 2'b10;
        cyc(3);
        checks++;
        if (count !== 4'd15 || dir !== 1'b1 || step !== 1'b1) begin
            errors++; $display("FAIL rev_wrap1: count=%0d dir=%0d step=%0d expected 15/1/1", count, dir, step);
        end
        cyc(1);
        {qa, qb} = 2'b11;
        cyc(3);
        checks++;
        if (count !== 4'd14 || dir !== 1'b1 || step !== 1'b1) begin
            errors++; $display("FAIL rev_wrap2: count=%0d dir=%0d step=%0d expected 14/1/1", count, dir, step);
        end
        cyc(1);
    endtask

    task automatic test_up_wrap;
        {qa, qb} = 2'b10;
        cyc(3);
        checks++;
        if (count !== 4'd15 || dir !== 1'b0) begin
            errors++; $display("FAIL upwrap_to15: count=%0d dir=%0d expected 15/0", count, dir);
        end
        cyc(1);
        {qa, qb} = 2'b00;
        cyc(3);
        checks++;
        if (count !== 4'd0 || dir !== 1'b0 || step !== 1'b1) begin
            errors++; $display("FAIL upwrap_to0: count=%0d dir=%0d step=%0d expected 0/0/1", count, dir, step);
        end
        cyc(1);
    endtask

    task automatic test_illegal;
        {qa, qb} = 2'b11;
        cyc(2);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL illegal_early: err=%0d expected 0", err);
        end
        cyc(1);
        checks++;
        if (err !== 1'b1 || step !== 1'b0 || count !== 4'd0) begin
            errors++; $display("FAIL illegal_pulse: err=%0d step=%0d count=%0d expected 1/0/0", err, step, count);
        end
        cyc(1);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL illegal_one_cycle: err=%0d expected 0", err);
        end
        {qa, qb} = 2'b10;
        cyc(3);
        checks++;
        if (count !== 4'd1 || step !== 1'b1 || dir !== 1'b0) begin
            errors++; $display("FAIL illegal_then_fwd: count=%0d step=%0d dir=%0d expected 1/1/0", count, step, dir);
        end
        cyc(1);
    endtask

    task automatic test_enable;
        logic [1:0] seq [3];
        seq = '{2'b00, 2'b01, 2'b11};
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            {qa, qb} = seq[i];
            for (int k = 0; k < 4; k++) begin
                cyc(1);
                checks++;
                if (step !== 1'b0 || count !== 4'd1) begin
                    errors++; $display("FAIL en_hold i=%0d k=%0d: step=%0d count=%0d expected 0/1", i, k, step, count);
                end
            end
        end
        {qa, qb} = 2'b00;
        cyc(3);
        checks++;
        if (err !== 1'b1 || count !== 4'd1) begin
            errors++; $display("FAIL en_err_reported: err=%0d count=%0d expected 1/1", err, count);
        end
        cyc(1);
        en = 1'b1;
        cyc(4);
        checks++;
        if (count !== 4'd1 || step !== 1'b0) begin
            errors++; $display("FAIL en_no_replay: count=%0d step=%0d expected 1/0", count, step);
        end
    endtask

    task automatic test_reset_mid;
        {qa, qb} = 2'b01;
        rst = 1'b1;
        cyc(1);
        checks++;
        if (count !== 4'd0 || step !== 1'b0) begin
            errors++; $display("FAIL midrst_clear: count=%0d step=%0d expected 0/0", count, step);
        end
        {qa, qb} = 2'b11;
        cyc(1);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            checks++;
            if (count !== 4'd0 || step !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL midrst_prime k=%0d: count=%0d step=%0d err=%0d expected 0/0/0", k, count, step, err);
            end
        end
        {qa, qb} = 2'b10;
        cyc(3);
        checks++;
        if (count !== 4'd1 || step !== 1'b1) begin
            errors++; $display("FAIL midrst_resume: count=%0d step=%0d expected 1/1", count, step);
        end
        cyc(1);
    endtask

`ifdef QDEC_INDEX_EN
    task automatic test_index;
        logic [1:0] seq [8];
        seq = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
        for (int i = 0; i < 8; i++) begin
            {qa, qb} = seq[i];
            cyc(4);
        end
        checks++;
        if (count !== 4'd9) begin
            errors++; $display("FAIL idx_pre: count=%0d expected 9", count);
        end
        idx = 1'b1;
        cyc(2);
        checks++;
        if (count !== 4'd9) begin
            errors++; $display("FAIL idx_early: count=%0d expected 9", count);
        end
        cyc(1);
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL idx_zero: count=%0d expected 0", count);
        end
        idx = 1'b0;
        cyc(2);
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL idx_hold: count=%0d expected 0", count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_up_wrap();
        test_illegal();
        test_enable();
        test_reset_mid();
`ifdef QDEC_INDEX_EN
        test_index();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
